spmv_mac: RTL and testbench
===========================

Name: spmv_mac

Overview:
Double-precision multiply-accumulate for the sparse matrix-vector pipeline. For each write it multiplies v0 by v1 and adds the product into one of INTERMEDIATOR_DEPTH per-row partial sums. On an eof pulse it emits one IEEE-754 double per touched row. Internally all arithmetic runs in FloPoCo format; results return to IEEE through the flopoco_to_ieee sub-module.

Parameters:
INTERMEDIATOR_DEPTH, 8, number of row slots; positional parameter 0.
LOG2_INTERMEDIATOR_DEPTH, log2(INTERMEDIATOR_DEPTH-1), row index width (3 for the default); uses the codebase log2 function.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
wr  in  1  input valid; ignored while stall=1.
row  in  LOG2_INTERMEDIATOR_DEPTH  destination row slot.
v0  in  64  IEEE double multiplicand (matrix value).
v1  in  64  IEEE double multiplier (vector value).
push_out  out  1  result valid, single-cycle.
v_out  out  64  IEEE double row sum.
eof  in  1  single-cycle end-of-batch pulse.
stall  out  1  upstream backpressure.
stall_out  in  1  downstream backpressure; no push_out while it is high.

Behaviour:
- Reset values: push_out=0, v_out=0, stall=0. All slots invalid, FIFO empty, eof latch clear, window_end=0.
- Input stage: v0 and v1 go through IEEE-to-FloPoCo conversion with 66-bit format {exn[1:0],sign,exp[10:0],frac[51:0]}. Output valid is named flopoco_conv_push.
- Multiplier: FloPoCo FPMult, fixed latency MULT_LATENCY. Row travels alongside. Internal outputs are named multiplier_push, multiplier_out and multiplier_row.
- Intermediator (instance intermediator_inst): slot array of INTERMEDIATOR_DEPTH entries, each a {valid, 66-bit value}, plus a 16-entry overflow_fifo of {row, value}.
  - Each cycle it processes exactly one incoming value, in priority order: adder result, then FIFO head, then multiplier product.
  - An unselected multiplier product is pushed into the FIFO.
  - For incoming value for row r: if slot r is invalid, store the value and set valid. If slot r is valid, send the pair (slot, incoming) to the adder on intermediator_push_to_adder, intermediator_v0_to_adder and intermediator_v1_to_adder, then clear the slot.
- Adder: FloPoCo FPAdd, latency ADD_LATENCY, row carried alongside. Outputs adder_push_out and adder_out return to the intermediator.
- stall: asserted when FIFO count >= 16-(MULT_LATENCY+2), registered.
- eof handling:
  - eof latches.
  - Flush starts when the latch is set, nothing is in flight in the multiplier or adder, and the FIFO is empty.
  - window_end scans slots 0..DEPTH-1 in ascending order, one slot per cycle, and only advances while stall_out=0.
  - Each valid slot is sent through flopoco_to_ieee to push_out/v_out. Invalid slots are skipped without a push.
  - After the last slot, all slots are cleared, the latch is cleared and window_end=0.
  - wr is accepted during a flush but stall is held at 1 for the flush.
- A row with exactly one product is emitted unmodified, with no addition.
- Summation order is not defined; results must be bit-exact only when addition order does not matter.
- Reset mid-operation discards all data; no push_out occurs afterwards.

flopoco_to_ieee(clk, push_in, in[65:0], push_out, out[63:0]):
- Registered, 1-cycle latency, no reset.
- push_out is push_in delayed by one cycle.
- Conversion by exn: 00 gives {sign,63'b0}; 01 gives {sign,exp,frac}; 10 gives {sign,11'h7FF,52'b0}; 11 gives 64'h7FF8000000000000.
- It is also used standalone for debug taps on multiplier and adder outputs.

Decomposition:
- Package spmv_mac_pkg holds the constants FLOPOCO_W=66, MULT_LATENCY, ADD_LATENCY, OVF_FIFO_DEPTH=16 and the exn encodings.
- Sub-module flopoco_to_ieee is separate.
- FPMult, FPAdd and ieee_to_flopoco are existing FloPoCo cores.
- Intermediator logic is inline in spmv_mac.

Test Plan:
- Reset, then row=2, v0=1.5, v1=2.0, then eof: exactly one push_out, v_out=64'h4008000000000000 (3.0).
- Row 0 with (1.0,2.0) and (3.0,4.0), eof: v_out=64'h402C000000000000 (14.0).
- Rows 3 and 1 with products 2.0 and 5.0, eof: pushes in ascending row order, 64'h4014000000000000 (row 1) then 64'h4000000000000000 (row 3).
- 25 back-to-back writes to row 1, each 1.0*1.0, honouring stall: single v_out=64'h4039000000000000 (25.0); no write is lost.
- stall_out held 1 during the flush: no push_out; after release the results appear unchanged.
- flopoco_to_ieee standalone: exn=11 gives 64'h7FF8000000000000 and exn=00 with sign=1 gives 64'h8000000000000000, each one cycle after push_in.

Source files
------------

// File: rtl/spmv_mac_pkg.sv
// rtl/spmv_mac_pkg.sv - FloPoCo double-precision constants and arithmetic helpers for spmv_mac
package spmv_mac_pkg;

    localparam int FLOPOCO_W       = 66;
    localparam int MULT_LATENCY    = 3;
    localparam int ADD_LATENCY     = 4;
    localparam int OVF_FIFO_DEPTH  = 16;
    localparam int FIFO_AW         = $clog2(OVF_FIFO_DEPTH);
    localparam int STALL_THRESHOLD = OVF_FIFO_DEPTH - (MULT_LATENCY + 2);

    localparam logic [1:0] EXN_ZERO   = 2'b00;
    localparam logic [1:0] EXN_NORMAL = 2'b01;
    localparam logic [1:0] EXN_INF    = 2'b10;
    localparam logic [1:0] EXN_NAN    = 2'b11;

    // Number of bits needed to hold value (log2(7) = 3).
    function automatic int log2(input int value);
        int n;
        n = 0;
        for (int i = 0; i < 31; i++) begin
            if ((value >> i) != 0) n = i + 1;
        end
        return n;
    endfunction

    // Subnormal IEEE inputs are flushed to signed zero.
    function automatic logic [FLOPOCO_W-1:0] ieee_to_flopoco(input logic [63:0] d);
        logic [1:0] exn;
        if (d[62:52] == 11'h000)      exn = EXN_ZERO;
        else if (d[62:52] == 11'h7FF) exn = (d[51:0] == 52'b0) ? EXN_INF : EXN_NAN;
        else                          exn = EXN_NORMAL;
        return (exn == EXN_NORMAL) ? {exn, d} : {exn, d[63], 63'b0};
    endfunction

    // Range check on the biased exponent after rounding.
    function automatic logic [FLOPOCO_W-1:0] fp_pack(input logic s, input logic signed [13:0] e,
                                                     input logic [51:0] f);
        if (e >= 14'sd2047) return {EXN_INF, s, 63'b0};
        if (e <= 14'sd0)    return {EXN_ZERO, s, 63'b0};
        return {EXN_NORMAL, s, e[10:0], f};
    endfunction

    // Round-to-nearest-even on a 53-bit significand with guard and sticky.
    function automatic logic [FLOPOCO_W-1:0] fp_round(input logic s, input logic signed [13:0] e,
                                                      input logic [52:0] m, input logic g,
                                                      input logic st);
        logic [53:0]        r;
        logic signed [13:0] e2;
        r  = {1'b0, m} + 54'(g & (st | m[0]));
        e2 = e;
        if (r[53]) begin
            r  = r >> 1;
            e2 = e + 14'sd1;
        end
        return fp_pack(s, e2, r[51:0]);
    endfunction

    function automatic logic [FLOPOCO_W-1:0] fp_mult(input logic [FLOPOCO_W-1:0] a,
                                                     input logic [FLOPOCO_W-1:0] b);
        logic               s;
        logic [105:0]       p;
        logic signed [13:0] e;
        s = a[63] ^ b[63];
        if (a[65:64] == EXN_NAN || b[65:64] == EXN_NAN ||
            (a[65:64] == EXN_INF && b[65:64] == EXN_ZERO) ||
            (a[65:64] == EXN_ZERO && b[65:64] == EXN_INF))
            return {EXN_NAN, 64'b0};
        if (a[65:64] == EXN_INF || b[65:64] == EXN_INF)   return {EXN_INF, s, 63'b0};
        if (a[65:64] == EXN_ZERO || b[65:64] == EXN_ZERO) return {EXN_ZERO, s, 63'b0};
        p = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
        e = $signed({3'b0, a[62:52]}) + $signed({3'b0, b[62:52]}) - 14'sd1023;
        if (p[105]) return fp_round(s, e + 14'sd1, p[105:53], p[52], |p[51:0]);
        return fp_round(s, e, p[104:52], p[51], |p[50:0]);
    endfunction

    function automatic logic [FLOPOCO_W-1:0] fp_add(input logic [FLOPOCO_W-1:0] a,
                                                    input logic [FLOPOCO_W-1:0] b);
        logic [63:0]        x;
        logic [63:0]        y;
        logic [10:0]        d;
        logic [55:0]        mx;
        logic [55:0]        my;
        logic [56:0]        sum;
        logic               sticky;
        logic signed [13:0] e;
        int                 lead;
        if (a[65:64] == EXN_NAN || b[65:64] == EXN_NAN ||
            (a[65:64] == EXN_INF && b[65:64] == EXN_INF && a[63] != b[63]))
            return {EXN_NAN, 64'b0};
        if (a[65:64] == EXN_INF) return a;
        if (b[65:64] == EXN_INF) return b;
        if (a[65:64] == EXN_ZERO) begin
            if (b[65:64] == EXN_ZERO) return {EXN_ZERO, a[63] & b[63], 63'b0};
            return b;
        end
        if (b[65:64] == EXN_ZERO) return a;
        // x is the operand of larger magnitude; its sign wins.
        if (a[62:0] >= b[62:0]) begin
            x = a[63:0];
            y = b[63:0];
        end else begin
            x = b[63:0];
            y = a[63:0];
        end
        d  = x[62:52] - y[62:52];
        mx = {1'b1, x[51:0], 3'b000};
        my = {1'b1, y[51:0], 3'b000};
        if (d >= 11'd56) begin
            sticky = 1'b1;
            my     = 56'b0;
        end else begin
            sticky = |(my & ((56'd1 << d) - 56'd1));
            my     = my >> d;
        end
        my[0] = my[0] | sticky;
        e     = $signed({3'b0, x[62:52]});
        if (x[63] == y[63]) begin
            sum = {1'b0, mx} + {1'b0, my};
            if (sum[56]) begin
                sum = {1'b0, sum[56:2], sum[1] | sum[0]};
                e   = e + 14'sd1;
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, my};
            if (sum == 57'b0) return {EXN_ZERO, 64'b0};
            lead = 0;
            for (int i = 0; i < 56; i++) begin
                if (sum[i]) lead = i;
            end
            sum = sum << (55 - lead);
            e   = e - 14'(55 - lead);
        end
        return fp_round(x[63], e, sum[55:3], sum[2], |sum[1:0]);
    endfunction

endpackage

// File: rtl/flopoco_to_ieee.sv
// rtl/flopoco_to_ieee.sv - registered FloPoCo-to-IEEE double conversion, 1-cycle latency
// Ports: clk; push_in/in = FloPoCo value {exn,sign,exp,frac}; push_out/out = IEEE double one cycle later.
module flopoco_to_ieee
    import spmv_mac_pkg::*;
(
    input  logic                 clk,
    input  logic                 push_in,
    input  logic [FLOPOCO_W-1:0] in,
    output logic                 push_out,
    output logic [63:0]          out
);

    always_ff @(posedge clk) begin
        push_out <= push_in;
        case (in[65:64])
            EXN_ZERO:   out <= {in[63], 63'b0};
            EXN_NORMAL: out <= in[63:0];
            EXN_INF:    out <= {in[63], 11'h7FF, 52'b0};
            default:    out <= 64'h7FF8000000000000;
        endcase
    end

endmodule

// File: rtl/spmv_mac.sv
// rtl/spmv_mac.sv - double-precision per-row multiply-accumulate with eof-triggered row flush
// Ports: clk, rst (sync, active-high); wr/row/v0/v1 = product write; eof = end-of-batch pulse;
//        stall = upstream backpressure; push_out/v_out = one IEEE row sum per touched row;
//        stall_out = downstream backpressure.
module spmv_mac
    import spmv_mac_pkg::*;
#(
    parameter int INTERMEDIATOR_DEPTH      = 8,
    parameter int LOG2_INTERMEDIATOR_DEPTH = log2(INTERMEDIATOR_DEPTH - 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr,
    input  logic [LOG2_INTERMEDIATOR_DEPTH-1:0] row,
    input  logic [63:0]                         v0,
    input  logic [63:0]                         v1,
    output logic                                push_out,
    output logic [63:0]                         v_out,
    input  logic                                eof,
    output logic                                stall,
    input  logic                                stall_out
);

    localparam int         RW          = LOG2_INTERMEDIATOR_DEPTH;
    localparam logic [4:0] STALL_LEVEL = 5'(STALL_THRESHOLD);

    // Input conversion stage
    logic                 conv_push;
    logic                 flopoco_conv_push;
    logic [FLOPOCO_W-1:0] conv_v0;
    logic [FLOPOCO_W-1:0] conv_v1;
    logic [RW-1:0]        conv_row;

    // Multiplier and adder pipelines; the row rides alongside each value
    logic                 mult_push_q [MULT_LATENCY];
    logic [FLOPOCO_W-1:0] mult_val_q  [MULT_LATENCY];
    logic [RW-1:0]        mult_row_q  [MULT_LATENCY];
    logic                 multiplier_push;
    logic [FLOPOCO_W-1:0] multiplier_out;
    logic [RW-1:0]        multiplier_row;

    logic                 add_push_q [ADD_LATENCY];
    logic [FLOPOCO_W-1:0] add_val_q  [ADD_LATENCY];
    logic [RW-1:0]        add_row_q  [ADD_LATENCY];
    logic                 adder_push_out;
    logic [FLOPOCO_W-1:0] adder_out;
    logic [RW-1:0]        adder_row;

    // Intermediator state
    logic                 slot_valid [INTERMEDIATOR_DEPTH];
    logic [FLOPOCO_W-1:0] slot_val   [INTERMEDIATOR_DEPTH];
    logic [RW-1:0]        fifo_row   [OVF_FIFO_DEPTH];
    logic [FLOPOCO_W-1:0] fifo_val   [OVF_FIFO_DEPTH];
    logic [FIFO_AW-1:0]   fifo_wp;
    logic [FIFO_AW-1:0]   fifo_rp;
    logic [FIFO_AW:0]     fifo_count;

    logic                 sel_adder;
    logic                 sel_fifo;
    logic                 sel_mult;
    logic                 in_valid;
    logic [RW-1:0]        in_row;
    logic [FLOPOCO_W-1:0] in_val;
    logic                 slot_store;
    logic                 slot_clear;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 intermediator_push_to_adder;
    logic [FLOPOCO_W-1:0] intermediator_v0_to_adder;
    logic [FLOPOCO_W-1:0] intermediator_v1_to_adder;
    logic [RW-1:0]        intermediator_row_to_adder;

    // Flush control
    logic                 eof_latch;
    logic                 flushing;
    logic [RW-1:0]        window_end;
    logic                 pipe_busy;
    logic                 flush_start;
    logic                 flush_step;
    logic                 flush_done;
    logic                 f2i_push;
    logic [FLOPOCO_W-1:0] f2i_in;

    assign flopoco_conv_push = conv_push;
    assign multiplier_push   = mult_push_q[MULT_LATENCY-1];
    assign multiplier_out    = mult_val_q[MULT_LATENCY-1];
    assign multiplier_row    = mult_row_q[MULT_LATENCY-1];
    assign adder_push_out    = add_push_q[ADD_LATENCY-1];
    assign adder_out         = add_val_q[ADD_LATENCY-1];
    assign adder_row         = add_row_q[ADD_LATENCY-1];

    // During a flush wr is still taken while the FIFO has room for everything in flight.
    always_ff @(posedge clk) begin
        if (rst) conv_push <= 1'b0;
        else     conv_push <= wr && (!stall || (flushing && fifo_count < STALL_LEVEL));
        conv_v0  <= ieee_to_flopoco(v0);
        conv_v1  <= ieee_to_flopoco(v1);
        conv_row <= row;
    end

    always_ff @(posedge clk) begin
        for (int i = MULT_LATENCY - 1; i > 0; i--) begin
            mult_push_q[i] <= mult_push_q[i-1];
            mult_val_q[i]  <= mult_val_q[i-1];
            mult_row_q[i]  <= mult_row_q[i-1];
        end
        mult_push_q[0] <= flopoco_conv_push;
        mult_val_q[0]  <= fp_mult(conv_v0, conv_v1);
        mult_row_q[0]  <= conv_row;
        if (rst) begin
            for (int i = 0; i < MULT_LATENCY; i++) mult_push_q[i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = ADD_LATENCY - 1; i > 0; i--) begin
            add_push_q[i] <= add_push_q[i-1];
            add_val_q[i]  <= add_val_q[i-1];
            add_row_q[i]  <= add_row_q[i-1];
        end
        add_push_q[0] <= intermediator_push_to_adder;
        add_val_q[0]  <= fp_add(intermediator_v0_to_adder, intermediator_v1_to_adder);
        add_row_q[0]  <= intermediator_row_to_adder;
        if (rst) begin
            for (int i = 0; i < ADD_LATENCY; i++) add_push_q[i] <= 1'b0;
        end
    end

    // One value per cycle: adder result first so partial sums never stall,
    // then FIFO backlog, then a fresh product. While flushing, products park in the FIFO.
    always_comb begin : intermediator_inst
        sel_adder                   = adder_push_out;
        sel_fifo                    = 1'b0;
        sel_mult                    = 1'b0;
        in_valid                    = 1'b0;
        in_row                      = '0;
        in_val                      = '0;
        slot_store                  = 1'b0;
        slot_clear                  = 1'b0;
        intermediator_push_to_adder = 1'b0;
        intermediator_v0_to_adder   = '0;
        intermediator_v1_to_adder   = '0;
        intermediator_row_to_adder  = '0;
        if (!flushing) begin
            sel_fifo = !sel_adder && (fifo_count != '0);
            sel_mult = !sel_adder && !sel_fifo && multiplier_push;
        end
        fifo_push = multiplier_push && !sel_mult && (fifo_count != (FIFO_AW+1)'(OVF_FIFO_DEPTH));
        fifo_pop  = sel_fifo;
        if (sel_adder) begin
            in_valid = 1'b1;
            in_row   = adder_row;
            in_val   = adder_out;
        end else if (sel_fifo) begin
            in_valid = 1'b1;
            in_row   = fifo_row[fifo_rp];
            in_val   = fifo_val[fifo_rp];
        end else if (sel_mult) begin
            in_valid = 1'b1;
            in_row   = multiplier_row;
            in_val   = multiplier_out;
        end
        if (in_valid) begin
            if (slot_valid[in_row]) begin
                intermediator_push_to_adder = 1'b1;
                intermediator_v0_to_adder   = slot_val[in_row];
                intermediator_v1_to_adder   = in_val;
                intermediator_row_to_adder  = in_row;
                slot_clear                  = 1'b1;
            end else begin
                slot_store = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_row[fifo_wp] <= multiplier_row;
            fifo_val[fifo_wp] <= multiplier_out;
        end
        if (rst) begin
            fifo_wp    <= '0;
            fifo_rp    <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) fifo_wp <= fifo_wp + FIFO_AW'(1);
            if (fifo_pop)  fifo_rp <= fifo_rp + FIFO_AW'(1);
            fifo_count <= fifo_count + (FIFO_AW+1)'(fifo_push) - (FIFO_AW+1)'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (slot_store) slot_val[in_row] <= in_val;
        if (rst) begin
            for (int i = 0; i < INTERMEDIATOR_DEPTH; i++) slot_valid[i] <= 1'b0;
        end else if (flush_done) begin
            for (int i = 0; i < INTERMEDIATOR_DEPTH; i++) slot_valid[i] <= 1'b0;
        end else begin
            if (slot_store) slot_valid[in_row] <= 1'b1;
            if (slot_clear) slot_valid[in_row] <= 1'b0;
        end
    end

    always_comb begin
        pipe_busy = conv_push;
        for (int i = 0; i < MULT_LATENCY; i++) pipe_busy = pipe_busy | mult_push_q[i];
        for (int i = 0; i < ADD_LATENCY; i++)  pipe_busy = pipe_busy | add_push_q[i];
    end

    // Flush only once every product has settled into its slot.
    assign flush_start = eof_latch && !flushing && !pipe_busy && (fifo_count == '0);
    assign flush_step  = flushing && !stall_out;
    assign flush_done  = flush_step && (window_end == RW'(INTERMEDIATOR_DEPTH - 1));
    // Zero data when idle keeps v_out at 0 after reset even though the converter has no reset.
    assign f2i_push    = flush_step && slot_valid[window_end] && !rst;
    assign f2i_in      = f2i_push ? slot_val[window_end] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            eof_latch  <= 1'b0;
            flushing   <= 1'b0;
            window_end <= '0;
            stall      <= 1'b0;
        end else begin
            eof_latch <= eof || (eof_latch && !flush_done);
            if (flush_start) begin
                flushing   <= 1'b1;
                window_end <= '0;
            end else if (flush_done) begin
                flushing   <= 1'b0;
                window_end <= '0;
            end else if (flush_step) begin
                window_end <= window_end + RW'(1);
            end
            stall <= (fifo_count >= STALL_LEVEL) || flush_start || (flushing && !flush_done);
        end
    end

    flopoco_to_ieee u_flopoco_to_ieee (
        .clk      (clk),
        .push_in  (f2i_push),
        .in       (f2i_in),
        .push_out (push_out),
        .out      (v_out)
    );

endmodule

// File: tb/tb_spmv_mac.sv
// tb/tb_spmv_mac.sv - self-checking bench for spmv_mac and flopoco_to_ieee
module tb_spmv_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic [2:0]  row;
    logic [63:0] v0;
    logic [63:0] v1;
    logic        push_out;
    logic [63:0] v_out;
    logic        eof;
    logic        stall;
    logic        stall_out;

    logic        f2i_push_in;
    logic [65:0] f2i_in;
    logic        f2i_push_out;
    logic [63:0] f2i_out;

    int total = 0;
    int bad   = 0;
    int push_count = 0;
    logic stall_out_prev = 1'b0;

    real         acc [8];
    int          cnt [8];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];

    typedef struct packed {
        logic [2:0]  r;
        logic [63:0] a;
        logic [63:0] b;
    } wr_t;

    always #5 clk = ~clk;

    spmv_mac dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .row       (row),
        .v0        (v0),
        .v1        (v1),
        .push_out  (push_out),
        .v_out     (v_out),
        .eof       (eof),
        .stall     (stall),
        .stall_out (stall_out)
    );

    flopoco_to_ieee u_f2i (
        .clk      (clk),
        .push_in  (f2i_push_in),
        .in       (f2i_in),
        .push_out (f2i_push_out),
        .out      (f2i_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Compare process: every result push must match the next expected row sum.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_out_prev) check("no_push_under_stall_out", 64'(push_out), 64'd0);
            if (push_out) begin
                push_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_push", v_out, 64'hDEAD);
                end else begin
                    check("v_out", v_out, exp_q.pop_front());
                    got_q.push_back(v_out);
                end
            end
        end
        stall_out_prev = stall_out;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic [63:0] dbl(input int x);
        return $realtobits($itor(x));
    endfunction

    function automatic logic [63:0] rand_double();
        logic [63:0] d;
        d[63]    = 1'($urandom_range(0, 1));
        d[62:52] = 11'(923 + $urandom_range(0, 200));
        d[51:32] = 20'($urandom);
        d[31:0]  = $urandom;
        return d;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++) begin
            acc[r] = 0.0;
            cnt[r] = 0;
        end
    endtask

    task automatic do_write(input logic [2:0] r, input logic [63:0] a, input logic [63:0] b);
        int guard;
        guard = 0;
        while (stall && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 2000) check("stall_timeout", 64'd1, 64'd0);
        wr  = 1'b1;
        row = r;
        v0  = a;
        v1  = b;
        acc[r] = acc[r] + $bitstoreal(a) * $bitstoreal(b);
        cnt[r]++;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    // Rows are emitted in ascending order, one per touched row.
    task automatic finish_batch(input int hold);
        int guard;
        int base;
        for (int r = 0; r < 8; r++) begin
            if (cnt[r] > 0) exp_q.push_back($realtobits(acc[r]));
        end
        model_clear();
        if (hold > 0) stall_out = 1'b1;
        eof = 1'b1;
        @(posedge clk); #1;
        eof = 1'b0;
        if (hold > 0) begin
            base = push_count;
            repeat (hold) @(posedge clk);
            #1;
            check("pushes_while_held", 64'(push_count - base), 64'd0);
            stall_out = 1'b0;
        end
        guard = 0;
        while ((exp_q.size() != 0 || stall) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("flush_timeout", 64'(guard < 3000), 64'd1);
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        wr_t wq [$];
        wr_t tmp;
        int  n;
        int  j;
        int  base;

        rst = 1'b1; wr = 1'b0; row = '0; v0 = '0; v1 = '0; eof = 1'b0; stall_out = 1'b0;
        f2i_push_in = 1'b0; f2i_in = '0;
        model_clear();
        repeat (4) @(posedge clk);
        #1;
        check("reset_push_out", 64'(push_out), 64'd0);
        check("reset_v_out", v_out, 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single product passes through unmodified: 1.5 * 2.0
        got_q.delete();
        do_write(3'd2, 64'h3FF8000000000000, 64'h4000000000000000);
        finish_batch(0);
        check("t1_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check("t1_value", got_q[0], 64'h4008000000000000);

        // Two products into row 0: 1*2 + 3*4
        got_q.delete();
        do_write(3'd0, dbl(1), dbl(2));
        do_write(3'd0, dbl(3), dbl(4));
        finish_batch(0);
        check("t2_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check("t2_value", got_q[0], 64'h402C000000000000);

        // Written row 3 then row 1; emitted row 1 first
        got_q.delete();
        do_write(3'd3, dbl(1), dbl(2));
        do_write(3'd1, dbl(5), dbl(1));
        finish_batch(0);
        check("t3_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() > 1) begin
            check("t3_row1", got_q[0], 64'h4014000000000000);
            check("t3_row3", got_q[1], 64'h4000000000000000);
        end

        // 25 back-to-back writes into one row
        got_q.delete();
        for (int i = 0; i < 25; i++) do_write(3'd1, dbl(1), dbl(1));
        finish_batch(0);
        check("t4_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check("t4_value", got_q[0], 64'h4039000000000000);

        // Downstream held off across the whole flush
        got_q.delete();
        do_write(3'd4, dbl(2), dbl(3));
        do_write(3'd6, dbl(1), dbl(7));
        finish_batch(40);
        check("t5_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() > 1) begin
            check("t5_row4", got_q[0], 64'h4018000000000000);
            check("t5_row6", got_q[1], 64'h401C000000000000);
        end

        // Random integer batches: sums are exact so any addition order is bit-exact
        for (int b = 0; b < 4; b++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) begin
                j = $urandom_range(1, 8);
                if ($urandom_range(0, 1) == 1) j = -j;
                do_write(3'($urandom_range(0, 7)), dbl(j), dbl($urandom_range(1, 8)));
            end
            finish_batch((b == 2) ? 15 : 0);
        end

        // Random doubles, at most two products per row (two-operand sums are order-free)
        for (int b = 0; b < 4; b++) begin
            wq.delete();
            for (int r = 0; r < 8; r++) begin
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    tmp.r = 3'(r);
                    tmp.a = rand_double();
                    tmp.b = rand_double();
                    wq.push_back(tmp);
                end
            end
            for (int i = wq.size() - 1; i > 0; i--) begin
                j     = $urandom_range(0, i);
                tmp   = wq[i];
                wq[i] = wq[j];
                wq[j] = tmp;
            end
            foreach (wq[i]) do_write(wq[i].r, wq[i].a, wq[i].b);
            finish_batch(0);
        end

        // Reset with products in flight: nothing may come out afterwards
        do_write(3'd0, dbl(2), dbl(2));
        do_write(3'd5, dbl(3), dbl(3));
        do_write(3'd0, dbl(4), dbl(4));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        exp_q.delete();
        base = push_count;
        finish_batch(0);
        check("post_reset_pushes", 64'(push_count - base), 64'd0);
        check("post_reset_stall", 64'(stall), 64'd0);

        // Standalone converter: one-cycle latency for each exception class
        f2i_push_in = 1'b1; f2i_in = {2'b11, 1'b0, 63'h123};
        @(posedge clk); #1;
        check("f2i_nan_push", 64'(f2i_push_out), 64'd1);
        check("f2i_nan", f2i_out, 64'h7FF8000000000000);
        f2i_in = {2'b00, 1'b1, 63'h5};
        @(posedge clk); #1;
        check("f2i_negzero", f2i_out, 64'h8000000000000000);
        f2i_in = {2'b10, 1'b1, 63'h77};
        @(posedge clk); #1;
        check("f2i_neginf", f2i_out, 64'hFFF0000000000000);
        f2i_push_in = 1'b0; f2i_in = {2'b01, 64'h3FF8000000000000};
        @(posedge clk); #1;
        check("f2i_normal", f2i_out, 64'h3FF8000000000000);
        check("f2i_push_low", 64'(f2i_push_out), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
